// File: rtl/oflow_core_fsm_read.sv
// Core-side read sequencer: fetches one frame of bboxes (4 per beat) from the frame buffer and steers them into the PE array row by row.
// Optional WAIT_DATA watchdog enabled by defining OFLOW_CORE_FSM_READ_TIMEOUT_EN.
module oflow_core_fsm_read #(
  parameter int PE_NUM  = 24,
  parameter int BBOX_W  = 32,
  parameter int NUM_W   = 10,
  parameter int ADDR_W  = 10,
  parameter int ROW_LEN = 6,
  parameter int PE_LEN  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  start_read,
  input  logic [NUM_W-1:0]      num_of_bbox_in_frame,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [4*BBOX_W-1:0]   rd_data,
  output logic                  pe_we,
  output logic [4*BBOX_W-1:0]   pe_data,
  output logic [3:0]            valid_mask,
  output logic [ROW_LEN-1:0]    row_sel,
  output logic [PE_LEN-1:0]     pe_sel,
  output logic                  row_full,
  input  logic                  row_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_WRITE, S_ROW_DONE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_W-1:0]  n_lat, beat_idx, total_beats;
  logic [ADDR_W-1:0] base_lat;
  logic [3:0]        beat_mask;
  logic              start_ok, last_beat, last_in_row, frame_done, timeout_hit;

  assign start_ok    = start_read && (state == S_IDLE);
  assign total_beats = (n_lat >> 2) + NUM_W'(n_lat[1:0] != 2'b00);
  // beat_idx still points at the current beat until WRITE retires it.
  assign last_beat   = (beat_idx + NUM_W'(1)) == total_beats;
  assign frame_done  = beat_idx == total_beats;
  assign last_in_row = pe_sel == PE_LEN'(PE_NUM/4 - 1);

  assign rd_addr  = base_lat + ADDR_W'(beat_idx);
  assign rd_req   = state == S_REQ;
  assign pe_we    = state == S_WRITE;
  assign row_full = state == S_ROW_DONE;
  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;

`ifdef OFLOW_CORE_FSM_READ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == S_WAIT_DATA) && !rd_valid && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= (state == S_WAIT_DATA) ? to_cnt + TO_W'(1) : '0;
      if (start_ok)         err <= 1'b0;
      else if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    beat_mask = 4'b1111;
    if (last_beat) begin
      case (n_lat[1:0])
        2'd1:    beat_mask = 4'b0001;
        2'd2:    beat_mask = 4'b0011;
        2'd3:    beat_mask = 4'b0111;
        default: beat_mask = 4'b1111;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next state gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_read) state_nxt = (num_of_bbox_in_frame == '0) ? S_DONE : S_REQ;
      S_REQ:       if (rd_gnt) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (rd_valid)         state_nxt = S_WRITE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WRITE:     state_nxt = (last_in_row || last_beat) ? S_ROW_DONE : S_REQ;
      S_ROW_DONE:  if (row_ack) state_nxt = frame_done ? S_DONE : S_REQ;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      n_lat      <= '0;
      base_lat   <= '0;
      beat_idx   <= '0;
      row_sel    <= '0;
      pe_sel     <= '0;
      pe_data    <= '0;
      valid_mask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row_sel <= '0;
          pe_sel  <= '0;
          if (start_ok) begin
            n_lat    <= num_of_bbox_in_frame;
            base_lat <= base_addr;
            beat_idx <= '0;
          end
        end
        S_WAIT_DATA: if (rd_valid) begin
          pe_data    <= rd_data;
          valid_mask <= beat_mask;
        end
        S_WRITE: begin
          beat_idx <= beat_idx + NUM_W'(1);
          if (!(last_in_row || last_beat)) pe_sel <= pe_sel + PE_LEN'(1);
        end
        S_ROW_DONE: if (row_ack && !frame_done) begin
          row_sel <= row_sel + ROW_LEN'(1);
          pe_sel  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
